systolic_array_tile: RTL and testbench

Output-stationary NUM_ROWS x NUM_COLS MAC array that computes one C = A·B tile over a runtime-programmable reduction length K. It is the successor to the plain PE grid. It adds:
- internal operand skewing,
- a valid/ready input stream that tolerates gaps,
- a command/done control FSM,
- a row-serial result drain with backpressure.

It sits between the operand buffers and the result writeback in the accelerator datapath.

---
 rtl/systolic_array_tile_if.sv | 36 +++
 rtl/systolic_array_tile.sv | 160 ++++++++++++++++
 tb/tb_systolic_array_tile.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/systolic_array_tile_if.sv
// Command/status, operand stream and result-drain signals of systolic_array_tile.
// The slave modport is the tile side; master is the operand-buffer/writeback side.
interface systolic_array_tile_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_ROWS   = 4,
  parameter int NUM_COLS   = 4,
  parameter int MAX_K      = 256
);
  localparam int KW = $clog2(MAX_K + 1);
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  logic                           start_i;
  logic [KW-1:0]                  k_len_i;
  logic                           busy_o;
  logic                           in_valid_i;
  logic                           in_ready_o;
  logic [NUM_ROWS*DATA_WIDTH-1:0] a_data_i;
  logic [NUM_COLS*DATA_WIDTH-1:0] b_data_i;
  logic                           res_valid_o;
  logic                           res_ready_i;
  logic [NUM_COLS*ACC_WIDTH-1:0]  res_data_o;
  logic [RW-1:0]                  res_row_o;
  logic                           res_last_o;
  logic                           done_o;

  modport slave (
    input  start_i, k_len_i, in_valid_i, a_data_i, b_data_i, res_ready_i,
    output busy_o, in_ready_o, res_valid_o, res_data_o, res_row_o, res_last_o, done_o
  );

  modport master (
    output start_i, k_len_i, in_valid_i, a_data_i, b_data_i, res_ready_i,
    input  busy_o, in_ready_o, res_valid_o, res_data_o, res_row_o, res_last_o, done_o
  );
endinterface

// File: rtl/systolic_array_tile.sv
// Output-stationary MAC tile C = A*B; first result row K+NUM_ROWS+NUM_COLS-1 cycles after start.
// Operand stream tolerates valid gaps; result rows are held stable while res_ready_i is low.
module systolic_array_tile #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 32,
  parameter int NUM_ROWS   = 4,
  parameter int NUM_COLS   = 4,
  parameter int MAX_K      = 256
) (
  input logic                  clk_i,
  input logic                  rst_i,
  systolic_array_tile_if.slave io
);
  localparam int KW = $clog2(MAX_K + 1);
  localparam int RW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int SL = NUM_ROWS + NUM_COLS - 1;
  localparam int FW = $clog2(SL + 1);

  typedef enum logic [1:0] {IDLE, FEED, FLUSH, DRAIN} state_t;

  state_t                         state;
  logic [KW-1:0]                  k_len;
  logic [KW-1:0]                  beat_cnt;
  logic [FW-1:0]                  flush_cnt;
  // Row r taps its A chain at r+c for PE(r,c): the first r stages are the skew, the rest the rightward hops.
  logic signed [DATA_WIDTH-1:0]   a_sh  [NUM_ROWS][SL];
  logic                           a_tag [NUM_ROWS][SL];
  logic signed [DATA_WIDTH-1:0]   b_sh  [NUM_COLS][SL];
  logic                           b_tag [NUM_COLS][SL];
  logic signed [ACC_WIDTH-1:0]    acc   [NUM_ROWS][NUM_COLS];
  logic signed [2*DATA_WIDTH-1:0] prod  [NUM_ROWS][NUM_COLS];
  logic                           mac_en[NUM_ROWS][NUM_COLS];
  logic                           accept;
  logic                           start_ok;
  logic                           res_fire;

  assign accept   = io.in_valid_i && io.in_ready_o;
  assign start_ok = io.start_i && (io.k_len_i != '0) && (io.k_len_i <= KW'(MAX_K));
  assign res_fire = io.res_valid_o && io.res_ready_i;

  always_comb begin
    for (int r = 0; r < NUM_ROWS; r++) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        mac_en[r][c] = a_tag[r][r+c] && b_tag[c][r+c];
        prod[r][c]   = (2*DATA_WIDTH)'(a_sh[r][r+c]) * (2*DATA_WIDTH)'(b_sh[c][r+c]);
      end
    end
  end

  always_comb begin
    io.res_data_o = '0;
    if (io.res_valid_o) begin
      for (int c = 0; c < NUM_COLS; c++) begin
        io.res_data_o[c*ACC_WIDTH +: ACC_WIDTH] = acc[io.res_row_o][c];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state          <= IDLE;
      k_len          <= '0;
      beat_cnt       <= '0;
      flush_cnt      <= '0;
      io.busy_o      <= 1'b0;
      io.in_ready_o  <= 1'b0;
      io.res_valid_o <= 1'b0;
      io.res_row_o   <= '0;
      io.res_last_o  <= 1'b0;
      io.done_o      <= 1'b0;
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int i = 0; i < SL; i++) begin
          a_sh[r][i]  <= '0;
          a_tag[r][i] <= 1'b0;
        end
        for (int c = 0; c < NUM_COLS; c++) acc[r][c] <= '0;
      end
      for (int c = 0; c < NUM_COLS; c++) begin
        for (int i = 0; i < SL; i++) begin
          b_sh[c][i]  <= '0;
          b_tag[c][i] <= 1'b0;
        end
      end
    end else begin
      // Operand chains shift every cycle; stalls only inject zero tags.
      for (int r = 0; r < NUM_ROWS; r++) begin
        a_sh[r][0]  <= io.a_data_i[r*DATA_WIDTH +: DATA_WIDTH];
        a_tag[r][0] <= accept;
        for (int i = 1; i < SL; i++) begin
          a_sh[r][i]  <= a_sh[r][i-1];
          a_tag[r][i] <= a_tag[r][i-1];
        end
      end
      for (int c = 0; c < NUM_COLS; c++) begin
        b_sh[c][0]  <= io.b_data_i[c*DATA_WIDTH +: DATA_WIDTH];
        b_tag[c][0] <= accept;
        for (int i = 1; i < SL; i++) begin
          b_sh[c][i]  <= b_sh[c][i-1];
          b_tag[c][i] <= b_tag[c][i-1];
        end
      end
      for (int r = 0; r < NUM_ROWS; r++) begin
        for (int c = 0; c < NUM_COLS; c++) begin
          if (mac_en[r][c]) acc[r][c] <= acc[r][c] + ACC_WIDTH'(prod[r][c]);
        end
      end

      io.done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_ok) begin
            for (int r = 0; r < NUM_ROWS; r++) begin
              for (int c = 0; c < NUM_COLS; c++) acc[r][c] <= '0;
            end
            k_len         <= io.k_len_i;
            beat_cnt      <= '0;
            state         <= FEED;
            io.busy_o     <= 1'b1;
            io.in_ready_o <= 1'b1;
          end
        end
        FEED: begin
          if (accept) begin
            beat_cnt <= beat_cnt + KW'(1);
            if (beat_cnt + KW'(1) == k_len) begin
              state         <= FLUSH;
              flush_cnt     <= '0;
              io.in_ready_o <= 1'b0;
            end
          end
        end
        FLUSH: begin
          flush_cnt <= flush_cnt + FW'(1);
          if (flush_cnt == FW'(SL - 1)) begin
            state          <= DRAIN;
            io.res_valid_o <= 1'b1;
            io.res_row_o   <= '0;
            io.res_last_o  <= (NUM_ROWS == 1);
          end
        end
        DRAIN: begin
          if (res_fire) begin
            if (io.res_last_o) begin
              state          <= IDLE;
              io.busy_o      <= 1'b0;
              io.res_valid_o <= 1'b0;
              io.res_row_o   <= '0;
              io.res_last_o  <= 1'b0;
              io.done_o      <= 1'b1;
            end else begin
              io.res_row_o  <= io.res_row_o + RW'(1);
              io.res_last_o <= (io.res_row_o == RW'(NUM_ROWS - 2));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_systolic_array_tile.sv
// Directed bench for systolic_array_tile: a 32-bit and a 16-bit accumulator tile share one stimulus,
// driven from a vector table plus hand sequences for reset, abort and invalid-K corners.
module tb_systolic_array_tile;
  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  systolic_array_tile_if                   ifc   ();
  systolic_array_tile_if #(.ACC_WIDTH(16)) ifc16 ();

  assign ifc16.start_i     = ifc.start_i;
  assign ifc16.k_len_i     = ifc.k_len_i;
  assign ifc16.in_valid_i  = ifc.in_valid_i;
  assign ifc16.a_data_i    = ifc.a_data_i;
  assign ifc16.b_data_i    = ifc.b_data_i;
  assign ifc16.res_ready_i = ifc.res_ready_i;

  systolic_array_tile u_dut (.clk_i(clk), .rst_i(rst), .io(ifc));
  systolic_array_tile #(.ACC_WIDTH(16)) u_dut16 (.clk_i(clk), .rst_i(rst), .io(ifc16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int k;
    bit ident;
    int av;
    int bv;
    bit gaps;
    bit bp;
    bit abort;
    int exp32;
    int exp16;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"},      ifc.busy_o,      0);
    chk({tag, "_in_ready"},  ifc.in_ready_o,  0);
    chk({tag, "_res_valid"}, ifc.res_valid_o, 0);
    chk({tag, "_res_row"},   ifc.res_row_o,   0);
    chk({tag, "_res_last"},  ifc.res_last_o,  0);
    chk({tag, "_done"},      ifc.done_o,      0);
    chk({tag, "_data32"},    ifc.res_data_o,  0);
    chk({tag, "_data16"},    ifc16.res_data_o, 0);
  endtask

  task automatic abort_seq();
    int got = 0;
    ifc.start_i = 1'b1;
    ifc.k_len_i = 9'd4;
    @(negedge clk);
    ifc.start_i  = 1'b0;
    ifc.a_data_i = {4{8'sd5}};
    ifc.b_data_i = {4{8'sd5}};
    for (int i = 0; i < 10 && got < 2; i++) begin
      ifc.in_valid_i = 1'b1;
      if (ifc.in_ready_o) got++;
      @(negedge clk);
    end
    ifc.in_valid_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_beats", got, 2);
    chk_outputs_zero("abort");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_done", ifc.done_o, 0);
  endtask

  task automatic bad_start(input logic [8:0] k);
    bit seen_busy = 1'b0;
    bit seen_done = 1'b0;
    ifc.start_i = 1'b1;
    ifc.k_len_i = k;
    @(negedge clk);
    ifc.start_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (ifc.busy_o) seen_busy = 1'b1;
      if (ifc.done_o) seen_done = 1'b1;
      @(negedge clk);
    end
    chk("bad_k_busy", seen_busy, 0);
    chk("bad_k_done", seen_done, 0);
  endtask

  task automatic run_vec(input vec_t v);
    int n = 0, bi = 0, acc_cnt = 0, rows = 0, dcyc = 0, done_cnt = 0;
    int first_v = -1, first_d = -1;
    bit fin = 1'b0;
    bit vv;
    logic [127:0] e32, e16;
    logic [31:0]  a_beat, b_beat;

    ifc.start_i     = 1'b1;
    ifc.k_len_i     = 9'(v.k);
    ifc.res_ready_i = 1'b1;
    @(negedge clk);
    ifc.start_i = 1'b0;
    chk("start_busy", ifc.busy_o, 1);

    while (!fin && n < 2000) begin
      if (ifc.res_valid_o) begin
        if (first_v < 0) first_v = n;
        e32 = '0;
        e16 = '0;
        for (int c = 0; c < 4; c++) begin
          e32[c*32 +: 32] = v.ident ? 32'(4*rows + c) : 32'(v.exp32);
          e16[c*16 +: 16] = v.ident ? 16'(4*rows + c) : 16'(v.exp16);
        end
        chk("row_idx",    ifc.res_row_o,  rows);
        chk("row_last",   ifc.res_last_o, rows == 3);
        chk("row_data32", ifc.res_data_o, e32);
        chk("row_data16", ifc16.res_data_o, e16);
      end
      if (ifc.done_o) begin
        done_cnt++;
        if (first_d < 0) begin
          first_d = n;
          chk("done_busy_low",  ifc.busy_o,      0);
          chk("done_valid_low", ifc.res_valid_o, 0);
          chk("done_data_zero", ifc.res_data_o,  0);
        end
      end
      if (first_d >= 0 && n == first_d + 1) fin = 1'b1;

      if (bi < v.k) vv = v.gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
      else          vv = (first_v < 0);
      a_beat = 32'h5a5a_5a5a;
      b_beat = 32'ha5a5_a5a5;
      if (vv && bi < v.k) begin
        for (int r = 0; r < 4; r++) a_beat[r*8 +: 8] = v.ident ? 8'(r == bi) : 8'(v.av);
        for (int c = 0; c < 4; c++) b_beat[c*8 +: 8] = v.ident ? 8'(4*bi + c) : 8'(v.bv);
      end
      ifc.in_valid_i = vv;
      ifc.a_data_i   = a_beat;
      ifc.b_data_i   = b_beat;
      if (vv && ifc.in_ready_o) begin
        acc_cnt++;
        if (bi < v.k) bi++;
      end
      if (v.bp) begin
        if (ifc.res_valid_o) dcyc++;
        ifc.res_ready_i = (dcyc > 10) ? dcyc[0] : 1'b0;
      end else begin
        ifc.res_ready_i = 1'b1;
      end
      if (ifc.res_valid_o && ifc.res_ready_i) rows++;
      ifc.start_i = v.bp && ifc.res_valid_o && (dcyc == 3);
      @(negedge clk);
      n++;
    end
    ifc.in_valid_i  = 1'b0;
    ifc.start_i     = 1'b0;
    ifc.res_ready_i = 1'b1;

    chk("no_timeout",     n < 2000, 1);
    chk("done_pulses",    done_cnt, 1);
    chk("rows_delivered", rows,     4);
    chk("beats_consumed", acc_cnt,  v.k);
    if (!v.gaps) chk("first_valid_latency", first_v, v.k + 7);
    if (!v.gaps && !v.bp) chk("done_latency", first_d, v.k + 11);
    repeat (2) @(negedge clk);
    chk("idle_after_tile", ifc.busy_o, 0);
  endtask

  initial begin
    // k, ident, a, b, gaps, backpressure, abort-first, expected C (32-bit), expected C (16-bit)
    tbl[0] = '{4,   1'b1, 0,    0,    1'b0, 1'b0, 1'b0, 0,       0};
    tbl[1] = '{4,   1'b1, 0,    0,    1'b1, 1'b0, 1'b0, 0,       0};
    tbl[2] = '{4,   1'b1, 0,    0,    1'b0, 1'b1, 1'b0, 0,       0};
    tbl[3] = '{256, 1'b0, -128, -128, 1'b0, 1'b0, 1'b0, 4194304, 0};
    tbl[4] = '{4,   1'b0, 127,  127,  1'b0, 1'b0, 1'b0, 64516,   -1020};
    tbl[5] = '{3,   1'b0, 127,  -128, 1'b0, 1'b0, 1'b0, -48768,  16768};
    tbl[6] = '{7,   1'b0, -3,   5,    1'b1, 1'b0, 1'b0, -105,    -105};
    tbl[7] = '{1,   1'b0, 3,    3,    1'b0, 1'b0, 1'b1, 9,       9};

    rst             = 1'b1;
    ifc.start_i     = 1'b0;
    ifc.k_len_i     = '0;
    ifc.in_valid_i  = 1'b0;
    ifc.a_data_i    = '0;
    ifc.b_data_i    = '0;
    ifc.res_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_outputs_zero("reset");
    rst = 1'b0;
    @(negedge clk);

    bad_start(9'd0);
    bad_start(9'd257);

    for (int i = 0; i < 8; i++) begin
      if (tbl[i].abort) abort_seq();
      run_vec(tbl[i]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
